// File: rtl/seg_display_scheduler_pkg.sv
// Shared types for the seven-segment display scheduler: slot word, FSM states,
// and the source-index width helper.
package seg_disp_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] slot_word_t;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    PINNED
  } state_t;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// Requester/display bundle between the slot writers and the display scheduler.
interface seg_display_scheduler_if #(
  parameter int NUM_SRC = 4
);
  localparam int SRC_W = seg_disp_pkg::src_w(NUM_SRC);
  localparam int WORD_W = seg_disp_pkg::WORD_W;

  logic [NUM_SRC-1:0]        wr_valid;
  logic [NUM_SRC*WORD_W-1:0] wr_data;
  logic [NUM_SRC-1:0]        wr_ready;
  logic [NUM_SRC-1:0]        clr;
  logic                      pin_valid;
  logic [SRC_W-1:0]          pin_src;
  logic [WORD_W-1:0]         val;
  logic [SRC_W-1:0]          cur_src;
  logic                      cur_valid;
  logic                      switch_pls;

  modport master (
    output wr_valid, wr_data, clr, pin_valid, pin_src,
    input  wr_ready, val, cur_src, cur_valid, switch_pls
  );

  modport slave (
    input  wr_valid, wr_data, clr, pin_valid, pin_src,
    output wr_ready, val, cur_src, cur_valid, switch_pls
  );

endinterface

// File: rtl/seg_display_scheduler_rr_next_sel.sv
// Cyclic search for the next set bit of an occupancy mask, starting at (incl=1)
// or just after (incl=0) the start index.
module rr_next_sel
  import seg_disp_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] occ,
  input  logic [SRC_W-1:0]   start,
  input  logic               incl,
  output logic [SRC_W-1:0]   idx,
  output logic               found
);

  logic [SRC_W-1:0] pos;

  // Exclusive search visits start last, so a lone occupied start is re-selected.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos = SRC_W'((int'(start) + k + (incl ? 0 : 1)) % NUM_SRC);
      if (!found && occ[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin sharing of one 8-digit display among NUM_SRC requester slots,
// with dwell timing, pin override and a registered output stage.
module seg_display_scheduler
  import seg_disp_pkg::*;
#(
  parameter int         NUM_SRC      = 4,
  parameter int         DWELL_CYCLES = 100_000_000,
  parameter slot_word_t BLANK_VAL    = 32'h0
) (
  input logic clk,
  input logic rst,
  seg_display_scheduler_if.slave bus
);

  localparam int SRC_W = src_w(NUM_SRC);
  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [SRC_W:0]   NUM_SRC_X = (SRC_W+1)'(NUM_SRC);
  localparam logic [SRC_W-1:0] SRC_LAST  = SRC_W'(NUM_SRC - 1);

  slot_word_t         data_p0 [NUM_SRC];
  logic [NUM_SRC-1:0] occ_p0;

  state_t             state_p0, state_d;
  logic [SRC_W-1:0]   cur_p0, cur_d;
  logic [CNT_W-1:0]   cnt_p0, cnt_d;
  logic               sw_p0, sw_d;

  slot_word_t         val_p1;
  logic [SRC_W-1:0]   cur_src_p1;
  logic               vld_p1;
  logic               sw_p1;

  logic [SRC_W-1:0]   sel_start;
  logic               sel_incl;
  logic [SRC_W-1:0]   nxt_idx;
  logic               nxt_found;
  logic               pin_hit;

  assign bus.wr_ready = ~bus.clr;

  // Slot storage: clear beats a same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) data_p0[i] <= '0;
      occ_p0 <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bus.clr[i]) begin
          occ_p0[i] <= 1'b0;
        end else if (bus.wr_valid[i]) begin
          data_p0[i] <= bus.wr_data[i*WORD_W +: WORD_W];
          occ_p0[i]  <= 1'b1;
        end
      end
    end
  end

  assign sel_incl  = (state_p0 == IDLE);
  assign sel_start = (state_p0 != IDLE) ? cur_p0 :
                     (cur_p0 == SRC_LAST) ? '0 : cur_p0 + SRC_W'(1);
  assign pin_hit   = bus.pin_valid && ({1'b0, bus.pin_src} < NUM_SRC_X) && occ_p0[bus.pin_src];

  rr_next_sel #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_next_sel (
    .occ   (occ_p0),
    .start (sel_start),
    .incl  (sel_incl),
    .idx   (nxt_idx),
    .found (nxt_found)
  );

  always_comb begin
    state_d = state_p0;
    cur_d   = cur_p0;
    cnt_d   = cnt_p0;
    sw_d    = 1'b0;
    if (pin_hit) begin
      state_d = PINNED;
      cur_d   = bus.pin_src;
      cnt_d   = '0;
      sw_d    = (state_p0 == IDLE) || (cur_p0 != bus.pin_src);
    end else begin
      unique case (state_p0)
        IDLE: begin
          if (nxt_found) begin
            state_d = SHOW;
            cur_d   = nxt_idx;
            cnt_d   = '0;
            sw_d    = 1'b1;
          end
        end
        SHOW, PINNED: begin
          // A pin that is no longer valid leaves exactly like a cleared or expired slot.
          if (state_p0 == PINNED || !occ_p0[cur_p0] || cnt_p0 == CNT_LAST) begin
            cnt_d = '0;
            if (nxt_found) begin
              state_d = SHOW;
              cur_d   = nxt_idx;
              sw_d    = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_p0 + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage p0: scheduler state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= IDLE;
      cur_p0   <= '0;
      cnt_p0   <= '0;
      sw_p0    <= 1'b0;
    end else begin
      state_p0 <= state_d;
      cur_p0   <= cur_d;
      cnt_p0   <= cnt_d;
      sw_p0    <= sw_d;
    end
  end

  // Stage p1: registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_p1     <= BLANK_VAL;
      cur_src_p1 <= '0;
      vld_p1     <= 1'b0;
      sw_p1      <= 1'b0;
    end else begin
      val_p1     <= (state_p0 == IDLE) ? BLANK_VAL : data_p0[cur_p0];
      cur_src_p1 <= cur_p0;
      vld_p1     <= (state_p0 != IDLE);
      sw_p1      <= sw_p0;
    end
  end

  assign bus.val        = val_p1;
  assign bus.cur_src    = cur_src_p1;
  assign bus.cur_valid  = vld_p1;
  assign bus.switch_pls = sw_p1;

endmodule
